// File: rtl/mem_axi_master.sv
// rtl/mem_axi_master.sv - single-outstanding AXI master bridge for MEM-stage load/store requests
// Optional macro AXI_PERF_CNT_EN adds read/write/busy-cycle performance counters.
module mem_axi_master #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [2:0]  SIZE_CODE = 3'b010
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                axi_start,
    input  logic                axi_rw,
    input  logic [ADDR_W-1:0]   axi_addr,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic                axi_done,
    output logic                axi_busy,
    output logic                axi_err,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arsize,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awsize,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
`ifdef AXI_PERF_CNT_EN
    ,
    output logic [31:0]         perf_rd_cnt,
    output logic [31:0]         perf_wr_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_AR, S_RD_R, S_WR_DATA, S_WR_AWW, S_WR_B, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        done_d    = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        case (state_q)
            S_IDLE: begin
                if (axi_start) begin
                    addr_d = axi_addr;
                    if (axi_rw) begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_AR;
                    end else if (axi_wvalid) begin
                        data_d    = axi_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_AWW;
                    end else begin
                        state_d   = S_WR_DATA;
                    end
                end
            end
            S_RD_AR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_rdata;
                    err_d    = (m_rresp != 2'b00);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_WR_DATA: begin
                if (axi_wvalid) begin
                    data_d    = axi_wdata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR_AWW;
                end
            end
            S_WR_AWW: begin
                // AW and W retire independently; leave only when both have handshaken.
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    err_d    = (m_bresp != 2'b00);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            done_q    <= done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign axi_busy   = (state_q != S_IDLE);
    assign axi_wready = (state_q == S_IDLE) || (state_q == S_WR_DATA);
    assign axi_rdata  = rdata_q;
    assign axi_done   = done_q;
    assign axi_err    = err_q;
    assign m_araddr   = addr_q;
    assign m_arsize   = SIZE_CODE;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;
    assign m_awaddr   = addr_q;
    assign m_awsize   = SIZE_CODE;
    assign m_awvalid  = awvalid_q;
    assign m_wdata    = data_q;
    assign m_wstrb    = '1;
    assign m_wvalid   = wvalid_q;
    assign m_bready   = bready_q;

`ifdef AXI_PERF_CNT_EN
    logic        is_rd_q, is_rd_d;
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        is_rd_d     = (state_q == S_IDLE && axi_start) ? axi_rw : is_rd_q;
        rd_cnt_d    = rd_cnt_q + ((state_q == S_DONE && is_rd_q) ? 32'd1 : 32'd0);
        wr_cnt_d    = wr_cnt_q + ((state_q == S_DONE && !is_rd_q) ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (axi_busy ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_rd_q     <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            is_rd_q     <= is_rd_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_rd_cnt    = rd_cnt_q;
    assign perf_wr_cnt    = wr_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_axi_master.sv
// tb/tb_mem_axi_master.sv - directed self-checking bench for mem_axi_master
module tb_mem_axi_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        axi_start, axi_rw, axi_wvalid;
    logic [31:0] axi_addr, axi_wdata;
    logic        axi_wready, axi_done, axi_busy, axi_err;
    logic [31:0] axi_rdata;
    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
    logic [2:0]  m_arsize, m_awsize;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;
`ifdef AXI_PERF_CNT_EN
    logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_axi_master dut (
        .clk(clk), .resetn(resetn),
        .axi_start(axi_start), .axi_rw(axi_rw), .axi_addr(axi_addr),
        .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_rdata(axi_rdata), .axi_done(axi_done), .axi_busy(axi_busy), .axi_err(axi_err),
        .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef AXI_PERF_CNT_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Cycle c is observed at the c-th negedge after the start; inputs set there apply at the next posedge.
    task automatic run_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input int rv_at, input int restart_at,
                            output int done_at, output int ar_cnt, output logic [31:0] araddr_seen);
        @(negedge clk);
        axi_start = 1'b1; axi_rw = 1'b1; axi_addr = addr;
        m_arready = 1'b1; m_rdata = data; m_rresp = resp; m_rvalid = 1'b0;
        done_at = -1; ar_cnt = 0; araddr_seen = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (m_arvalid) begin
                ar_cnt++;
                araddr_seen = m_araddr;
            end
            if (axi_done && done_at < 0) done_at = c;
            if (done_at >= 0 && c > done_at) break;
            axi_start = (c == restart_at);
            axi_addr  = addr + 32'h10;
            m_rvalid  = (c >= rv_at);
        end
        axi_start = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                             input int wv_at, input int aw_at, input int w_at, input int bv_at,
                             output int done_at, output int aw_cnt, output int w_cnt, output int pre_cnt,
                             output logic [31:0] wdata_seen, output logic [31:0] awaddr_seen,
                             output logic [3:0] wstrb_seen, output logic wready_c2);
        @(negedge clk);
        axi_start = 1'b1; axi_rw = 1'b0; axi_addr = addr;
        axi_wvalid = (wv_at == 0); axi_wdata = (wv_at == 0) ? data : 32'h0;
        m_awready = (aw_at <= 0); m_wready = (w_at <= 0); m_bvalid = 1'b0; m_bresp = 2'b00;
        done_at = -1; aw_cnt = 0; w_cnt = 0; pre_cnt = 0;
        wdata_seen = '0; awaddr_seen = '0; wstrb_seen = '0; wready_c2 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (m_awvalid) begin
                aw_cnt++;
                awaddr_seen = m_awaddr;
            end
            if (m_wvalid) begin
                w_cnt++;
                wdata_seen = m_wdata;
                wstrb_seen = m_wstrb;
            end
            if ((m_awvalid || m_wvalid) && c <= wv_at) pre_cnt++;
            if (c == 2) wready_c2 = axi_wready;
            if (axi_done && done_at < 0) done_at = c;
            if (done_at >= 0 && c > done_at) break;
            axi_start  = 1'b0;
            axi_wvalid = (c == wv_at);
            axi_wdata  = (c == wv_at) ? data : 32'h0;
            m_awready  = (c >= aw_at);
            m_wready   = (c >= w_at);
            m_bvalid   = (c >= bv_at);
        end
        axi_start = 1'b0; axi_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        axi_start = 0; axi_rw = 0; axi_addr = 0; axi_wdata = 0; axi_wvalid = 0;
        m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (axi_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", axi_busy); end
        checks++; if (axi_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", axi_done); end
        checks++; if (axi_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", axi_rdata); end
        checks++; if (axi_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", axi_err); end
        checks++; if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 5'b0) begin
            errors++; $display("FAIL reset_valids got=%b exp=00000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
        end
        checks++; if (axi_wready !== 1'b1) begin errors++; $display("FAIL reset_wready got=%b exp=1", axi_wready); end
        checks++; if (m_arsize !== 3'b010 || m_awsize !== 3'b010) begin
            errors++; $display("FAIL reset_size got=%b/%b exp=010", m_arsize, m_awsize);
        end
    endtask

    task automatic test_read();
        int done_at, ar_cnt;
        logic [31:0] ara;
        run_read(32'h1000_0004, 32'hDEAD_BEEF, 2'b00, 2, 0, done_at, ar_cnt, ara);
        checks++; if (done_at !== 3) begin errors++; $display("FAIL read_latency got=%0d exp=3", done_at); end
        checks++; if (ar_cnt !== 1) begin errors++; $display("FAIL read_ar_cycles got=%0d exp=1", ar_cnt); end
        checks++; if (ara !== 32'h1000_0004) begin errors++; $display("FAIL read_araddr got=%h exp=10000004", ara); end
        repeat (2) @(negedge clk);
        checks++; if (axi_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got=%h exp=deadbeef", axi_rdata); end
        checks++; if (axi_err !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", axi_err); end
        checks++; if (axi_busy !== 1'b0) begin errors++; $display("FAIL read_idle_busy got=%b exp=0", axi_busy); end
    endtask

    task automatic test_write_data();
        int done_at, aw_cnt, w_cnt, pre_cnt;
        logic [31:0] wd, awa;
        logic [3:0] ws;
        logic wr2;
        run_write(32'h20, 32'h1234_5678, 0, 3, 1, 4, done_at, aw_cnt, w_cnt, pre_cnt, wd, awa, ws, wr2);
        checks++; if (w_cnt !== 1) begin errors++; $display("FAIL wr_wvalid_cycles got=%0d exp=1", w_cnt); end
        checks++; if (aw_cnt !== 3) begin errors++; $display("FAIL wr_awvalid_cycles got=%0d exp=3", aw_cnt); end
        checks++; if (done_at !== 5) begin errors++; $display("FAIL wr_done_cycle got=%0d exp=5", done_at); end
        checks++; if (wd !== 32'h1234_5678) begin errors++; $display("FAIL wr_wdata got=%h exp=12345678", wd); end
        checks++; if (awa !== 32'h20) begin errors++; $display("FAIL wr_awaddr got=%h exp=20", awa); end
        checks++; if (ws !== 4'hF) begin errors++; $display("FAIL wr_wstrb got=%h exp=f", ws); end
        checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL wr_wready_busy got=%b exp=0", wr2); end
    endtask

    task automatic test_write_nodata();
        int done_at, aw_cnt, w_cnt, pre_cnt;
        logic [31:0] wd, awa;
        logic [3:0] ws;
        logic wr2;
        run_write(32'h44, 32'hA5A5_A5A5, 4, 1, 1, 1, done_at, aw_cnt, w_cnt, pre_cnt, wd, awa, ws, wr2);
        checks++; if (pre_cnt !== 0) begin errors++; $display("FAIL nd_early_valid got=%0d exp=0", pre_cnt); end
        checks++; if (wd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL nd_wdata got=%h exp=a5a5a5a5", wd); end
        checks++; if (done_at !== 7) begin errors++; $display("FAIL nd_done_cycle got=%0d exp=7", done_at); end
        checks++; if (wr2 !== 1'b1) begin errors++; $display("FAIL nd_wready_wait got=%b exp=1", wr2); end
        checks++; if (axi_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nd_rdata_kept got=%h exp=deadbeef", axi_rdata); end
    endtask

    task automatic test_error_ignore();
        int done_at, ar_cnt, extra;
        logic [31:0] ara;
        run_read(32'h80, 32'h0BAD_F00D, 2'b10, 3, 2, done_at, ar_cnt, ara);
        checks++; if (done_at !== 4) begin errors++; $display("FAIL err_done_cycle got=%0d exp=4", done_at); end
        checks++; if (ar_cnt !== 1) begin errors++; $display("FAIL err_ignore_ar got=%0d exp=1", ar_cnt); end
        checks++; if (ara !== 32'h80) begin errors++; $display("FAIL err_araddr got=%h exp=80", ara); end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_arvalid || axi_busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL err_no_queue got=%0d exp=0", extra); end
        checks++; if (axi_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", axi_err); end
        checks++; if (axi_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL err_rdata got=%h exp=0badf00d", axi_rdata); end
    endtask

    task automatic test_reset_mid();
        int done_at, ar_cnt, dseen;
        logic [31:0] ara;
        @(negedge clk);
        axi_start = 1'b1; axi_rw = 1'b1; axi_addr = 32'h200; m_arready = 1'b1; m_rvalid = 1'b0;
        @(negedge clk);
        axi_start = 1'b0;
        @(negedge clk);
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL rst_mid_rready_before got=%b exp=1", m_rready); end
        resetn = 1'b0;
        #1;
        checks++; if (m_rready !== 1'b0 || axi_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop got=rready %b busy %b exp=0 0", m_rready, axi_busy);
        end
        dseen = 0;
        @(negedge clk);
        resetn = 1'b1; m_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (axi_done) dseen++;
        end
        m_rvalid = 1'b0;
        checks++; if (dseen !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", dseen); end
        run_read(32'h300, 32'h5555_AAAA, 2'b00, 2, 0, done_at, ar_cnt, ara);
        checks++; if (done_at !== 3) begin errors++; $display("FAIL rst_mid_next_latency got=%0d exp=3", done_at); end
        checks++; if (axi_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL rst_mid_next_rdata got=%h exp=5555aaaa", axi_rdata); end
    endtask

`ifdef AXI_PERF_CNT_EN
    task automatic test_perf();
        int d, a, w, p;
        logic [31:0] x, y;
        logic [3:0] s;
        logic r;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        run_read(32'h400, 32'h1, 2'b00, 3, 0, d, a, x);
        run_read(32'h404, 32'h2, 2'b00, 3, 0, d, a, x);
        run_write(32'h408, 32'h3, 0, 1, 1, 3, d, a, w, p, x, y, s, r);
        checks++; if (perf_rd_cnt !== 32'd2) begin errors++; $display("FAIL perf_rd got=%0d exp=2", perf_rd_cnt); end
        checks++; if (perf_wr_cnt !== 32'd1) begin errors++; $display("FAIL perf_wr got=%0d exp=1", perf_wr_cnt); end
        checks++; if (perf_stall_cnt !== 32'd12) begin errors++; $display("FAIL perf_stall got=%0d exp=12", perf_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_data();
        test_write_nodata();
        test_error_ignore();
        test_reset_mid();
`ifdef AXI_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
